duck_motion_ctl: RTL and testbench
==================================

Name: duck_motion_ctl

Overview:
Generates duck position and flight state for one hunt round. Sits directly upstream of the game-logic block: its duck_xpos/duck_ypos feed hit detection. It consumes that block's hunt_start and duck_killed to spawn, fly, fall and respawn ducks. Also drives the duck sprite renderer (visible, facing, falling flags).

Parameters:
SCREEN_W, 1024, active width in pixels
DUCK_W, 64, duck sprite width/height (square)
GROUND_Y, 600, y of grass line; lowest duck top = GROUND_Y-DUCK_W
MOVE_DIV, 650_000, clocks per movement tick (100 Hz at 65 MHz)
STEP, 4, pixels per tick in flight, each axis
FALL_STEP, 6, pixels per tick while falling
FLY_TICKS, 500, ticks in FLY before escaping
HIT_HOLD, 30, ticks frozen after a hit
LFSR_SEED, 16'hACE1, LFSR reset value, must be non-zero

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low (asserted when 0)
game_enable  in  1  level; low forces IDLE
hunt_start  in  1  level from game logic; high = rounds may run
duck_killed  in  1  one-cycle pulse from game logic on a hit
duck_xpos  out  12  duck top-left x
duck_ypos  out  12  duck top-left y
duck_visible  out  1  sprite enable
duck_facing_left  out  1  1 = moving toward x=0
duck_falling  out  1  high in HIT and FALL
duck_escaped  out  1  one-cycle pulse when duck leaves top of screen

Behaviour:
- Reset (rst=0, async): state IDLE, xpos=0, ypos=GROUND_Y-DUCK_W, visible=0, facing_left=0, falling=0, escaped=0, prescaler=0, counters=0, LFSR=LFSR_SEED.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock even in IDLE.
- Prescaler: counts 0..MOVE_DIV-1 while game_enable=1; tick = 1-cycle pulse on wrap; held at 0 while game_enable=0.
- States: IDLE, SPAWN, FLY, ESCAPE, HIT, FALL, DONE. All outputs registered.
- IDLE: visible=0. When game_enable&&hunt_start -> SPAWN.
- SPAWN (exactly 1 clk): x0=lfsr[9:0]; xpos = x0 if x0<=SCREEN_W-DUCK_W else x0-SCREEN_W/2. ypos=GROUND_Y-DUCK_W. facing_left=lfsr[10]; dy=up; fly_cnt=0; visible=1 -> FLY.
- FLY, per tick: x += STEP (right) or -STEP (left). If result <0 or >SCREEN_W-DUCK_W: clamp to bound, toggle facing_left same tick. y likewise within [0, GROUND_Y-DUCK_W], reversing dy at bounds. When fly_cnt[4:0]==31, dy <= lfsr[0]. fly_cnt++; on the tick where fly_cnt reaches FLY_TICKS -> ESCAPE.
- ESCAPE, per tick: x frozen; y -= STEP. If y<=STEP: y=0, visible=0, escaped=1 for one clk -> DONE.
- duck_killed in FLY or ESCAPE: -> HIT next clk. Position frozen; no movement even if tick coincides. falling=1; hold_cnt=0.
- duck_killed in any other state is ignored. Kill beats escape-completion in the same cycle (no escaped pulse).
- HIT: hold_cnt++ per tick; at HIT_HOLD -> FALL.
- FALL, per tick: y += FALL_STEP. If y >= GROUND_Y-DUCK_W: clamp, visible=0, falling=0 -> DONE.
- DONE: on next tick -> SPAWN if hunt_start=1, else IDLE.
- game_enable=0 in any state: next clk -> IDLE, visible=0, falling=0, position held, no escaped pulse.
- Widths: all position arithmetic uses 13-bit signed intermediates, so no wrap-around below 0 or above 4095.

Test Plan:
Use MOVE_DIV=4, FLY_TICKS=8, HIT_HOLD=2, GROUND_Y=600, DUCK_W=64, STEP=4, FALL_STEP=6 for all scenarios.
1. Reset -> rst=0 mid-FLY -> all outputs return to reset values immediately (async); ypos=536, visible=0.
2. Spawn -> game_enable=1, hunt_start=1 -> SPAWN 1 clk later, visible=1, xpos<=960, ypos=536; xpos changes by exactly 4 every 4 clks.
3. Edge bounce -> force xpos=958 moving right -> next tick xpos=960, facing_left=1; following tick xpos=956.
4. Escape -> no kill for 8 ticks -> ESCAPE; ypos falls by 4 per tick to 0; one-cycle duck_escaped; visible=0; SPAWN after 1 tick while hunt_start=1.
5. Kill + fall -> pulse duck_killed coincident with a tick -> position unchanged that tick; falling=1; frozen 2 ticks; ypos +6 per tick, clamped to 536; then visible=0, falling=0, no escaped pulse.
6. Disable / ignored kill -> duck_killed in IDLE has no effect; game_enable=0 during FALL -> IDLE next clk, visible=0, prescaler held at 0.

Source files
------------

// File: rtl/duck_motion_ctl.sv
// Duck flight controller: spawns a duck at a pseudo-random x, flies it with edge bounces,
// then lets it escape upward or, once shot, freezes, drops it to the grass line and respawns.
module duck_motion_ctl #(
  parameter int          SCREEN_W  = 1024,
  parameter int          DUCK_W    = 64,
  parameter int          GROUND_Y  = 600,
  parameter int          MOVE_DIV  = 650_000,
  parameter int          STEP      = 4,
  parameter int          FALL_STEP = 6,
  parameter int          FLY_TICKS = 500,
  parameter int          HIT_HOLD  = 30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_enable,
  input  logic        hunt_start,
  input  logic        duck_killed,
  output logic [11:0] duck_xpos,
  output logic [11:0] duck_ypos,
  output logic        duck_visible,
  output logic        duck_facing_left,
  output logic        duck_falling,
  output logic        duck_escaped
);

  localparam int PW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic signed [12:0] X_MAX  = 13'(SCREEN_W - DUCK_W);
  localparam logic signed [12:0] Y_MAX  = 13'(GROUND_Y - DUCK_W);
  localparam logic signed [12:0] STEP_S = 13'(STEP);
  localparam logic signed [12:0] FALL_S = 13'(FALL_STEP);
  localparam logic [11:0] X_TOP     = 12'(SCREEN_W - DUCK_W);
  localparam logic [11:0] Y_TOP     = 12'(GROUND_Y - DUCK_W);
  localparam logic [11:0] X_HALF    = 12'(SCREEN_W / 2);
  localparam logic [11:0] STEP_U    = 12'(STEP);
  localparam logic [15:0] FLY_LAST  = 16'(FLY_TICKS);
  localparam logic [15:0] HOLD_LAST = 16'(HIT_HOLD);

  typedef enum logic [2:0] {IDLE, SPAWN, FLY, ESCAPE, HIT, FALL, DONE} state_t;

  state_t         state_q, state_d;
  logic [11:0]    x_q, x_d, y_q, y_d;
  logic           vis_q, vis_d, left_q, left_d, fall_q, fall_d, esc_q, esc_d, up_q, up_d;
  logic [15:0]    fly_cnt_q, fly_cnt_d, hold_cnt_q, hold_cnt_d;
  logic [PW-1:0]  presc_q;
  logic [15:0]    lfsr_q;
  logic           tick;

  logic signed [12:0] x_s, y_s, x_mv, y_mv, fall_mv;
  logic [11:0]        x_clamp, y_clamp, x0;

  function automatic logic [11:0] clamp_pos(input logic signed [12:0] v,
                                            input logic signed [12:0] hi);
    if (v < 13'sd0)  return 12'd0;
    else if (v > hi) return hi[11:0];
    else             return v[11:0];
  endfunction

  function automatic logic out_of_range(input logic signed [12:0] v,
                                        input logic signed [12:0] hi);
    return (v < 13'sd0) || (v > hi);
  endfunction

  assign tick    = game_enable && (presc_q == PW'(MOVE_DIV - 1));
  assign x_s     = $signed({1'b0, x_q});
  assign y_s     = $signed({1'b0, y_q});
  assign x_mv    = left_q ? x_s - STEP_S : x_s + STEP_S;
  assign y_mv    = up_q   ? y_s - STEP_S : y_s + STEP_S;
  assign fall_mv = y_s + FALL_S;
  assign x_clamp = clamp_pos(x_mv, X_MAX);
  assign y_clamp = clamp_pos(y_mv, Y_MAX);
  assign x0      = {2'b00, lfsr_q[9:0]};

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    vis_d      = vis_q;
    left_d     = left_q;
    fall_d     = fall_q;
    esc_d      = 1'b0;
    up_d       = up_q;
    fly_cnt_d  = fly_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (!game_enable) begin
      state_d = IDLE;
      vis_d   = 1'b0;
      fall_d  = 1'b0;
    end else if ((state_q == FLY || state_q == ESCAPE) && duck_killed) begin
      // A hit freezes the duck even on a movement tick and pre-empts escape completion.
      state_d    = HIT;
      fall_d     = 1'b1;
      hold_cnt_d = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          vis_d = 1'b0;
          if (hunt_start) state_d = SPAWN;
        end
        SPAWN: begin
          x_d       = (x0 <= X_TOP) ? x0 : x0 - X_HALF;
          y_d       = Y_TOP;
          left_d    = lfsr_q[10];
          up_d      = 1'b1;
          fly_cnt_d = 16'd0;
          vis_d     = 1'b1;
          state_d   = FLY;
        end
        FLY: if (tick) begin
          x_d = x_clamp;
          if (out_of_range(x_mv, X_MAX)) left_d = ~left_q;
          y_d = y_clamp;
          if (fly_cnt_q[4:0] == 5'd31) up_d = lfsr_q[0];
          if (y_mv < 13'sd0)     up_d = 1'b0;
          else if (y_mv > Y_MAX) up_d = 1'b1;
          fly_cnt_d = fly_cnt_q + 16'd1;
          if (fly_cnt_d == FLY_LAST) state_d = ESCAPE;
        end
        ESCAPE: if (tick) begin
          if (y_s <= STEP_S) begin
            y_d     = 12'd0;
            vis_d   = 1'b0;
            esc_d   = 1'b1;
            state_d = DONE;
          end else begin
            y_d = y_q - STEP_U;
          end
        end
        HIT: if (tick) begin
          hold_cnt_d = hold_cnt_q + 16'd1;
          if (hold_cnt_d == HOLD_LAST) state_d = FALL;
        end
        FALL: if (tick) begin
          if (fall_mv >= Y_MAX) begin
            y_d     = Y_TOP;
            vis_d   = 1'b0;
            fall_d  = 1'b0;
            state_d = DONE;
          end else begin
            y_d = fall_mv[11:0];
          end
        end
        DONE: if (tick) state_d = hunt_start ? SPAWN : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      x_q        <= 12'd0;
      y_q        <= Y_TOP;
      vis_q      <= 1'b0;
      left_q     <= 1'b0;
      fall_q     <= 1'b0;
      esc_q      <= 1'b0;
      up_q       <= 1'b0;
      fly_cnt_q  <= 16'd0;
      hold_cnt_q <= 16'd0;
      presc_q    <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      vis_q      <= vis_d;
      left_q     <= left_d;
      fall_q     <= fall_d;
      esc_q      <= esc_d;
      up_q       <= up_d;
      fly_cnt_q  <= fly_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      presc_q    <= (!game_enable || tick) ? '0 : presc_q + PW'(1);
      lfsr_q     <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign duck_xpos        = x_q;
  assign duck_ypos        = y_q;
  assign duck_visible     = vis_q;
  assign duck_facing_left = left_q;
  assign duck_falling     = fall_q;
  assign duck_escaped     = esc_q;

endmodule

// File: tb/tb_duck_motion_ctl.sv
// Bench for duck_motion_ctl: vector table, directed corner sequences and a randomized run,
// all compared each cycle against an integer-arithmetic model of the duck's flight rules.
module tb_duck_motion_ctl;

  localparam int MOVE_DIV = 4;
  localparam int FLY_TICKS = 8;
  localparam int HIT_HOLD = 2;
  localparam int XMAX = 960;
  localparam int YMAX = 536;
  localparam int STEP = 4;
  localparam int FALL_STEP = 6;
  localparam int P_IDLE = 0, P_SPAWN = 1, P_FLY = 2, P_ESC = 3, P_HIT = 4, P_FALL = 5, P_DONE = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic game_enable = 1'b0;
  logic hunt_start = 1'b0;
  logic duck_killed = 1'b0;
  logic [11:0] duck_xpos, duck_ypos;
  logic duck_visible, duck_facing_left, duck_falling, duck_escaped;

  int checks = 0;
  int errors = 0;

  int m_ph, m_x, m_y, m_flights, m_hold, m_div;
  bit m_vis, m_left, m_fall, m_esc, m_up;
  bit [15:0] m_lfsr;

  typedef struct {
    bit ge; bit hs; bit kill; int n;
    bit vis; bit fall; bit esc; int y;
  } vec_t;
  vec_t tbl[13];

  duck_motion_ctl #(
    .MOVE_DIV(MOVE_DIV), .FLY_TICKS(FLY_TICKS), .HIT_HOLD(HIT_HOLD)
  ) dut (
    .clk(clk), .rst(rst), .game_enable(game_enable), .hunt_start(hunt_start),
    .duck_killed(duck_killed), .duck_xpos(duck_xpos), .duck_ypos(duck_ypos),
    .duck_visible(duck_visible), .duck_facing_left(duck_facing_left),
    .duck_falling(duck_falling), .duck_escaped(duck_escaped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit [15:0] lfsr_nx(input bit [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_ph = P_IDLE; m_x = 0; m_y = YMAX; m_vis = 0; m_left = 0; m_fall = 0; m_esc = 0;
    m_up = 0; m_flights = 0; m_hold = 0; m_div = 0; m_lfsr = 16'hACE1;
  endtask

  // One clock of the duck's life, from the rules in integer arithmetic.
  task automatic model_step(input bit ge, input bit hs, input bit kill);
    bit tick;
    bit [15:0] lf;
    int nx, ny;
    tick = ge && (m_div == MOVE_DIV - 1);
    lf = m_lfsr;
    m_lfsr = lfsr_nx(lf);
    m_div = ge ? (m_div + 1) % MOVE_DIV : 0;
    m_esc = 0;
    if (!ge) begin
      m_ph = P_IDLE; m_vis = 0; m_fall = 0;
    end else if ((m_ph == P_FLY || m_ph == P_ESC) && kill) begin
      m_ph = P_HIT; m_fall = 1; m_hold = 0;
    end else begin
      case (m_ph)
        P_IDLE: begin m_vis = 0; if (hs) m_ph = P_SPAWN; end
        P_SPAWN: begin
          nx = int'(lf[9:0]);
          m_x = (nx <= XMAX) ? nx : nx - 512;
          m_y = YMAX; m_left = lf[10]; m_up = 1; m_flights = 0; m_vis = 1; m_ph = P_FLY;
        end
        P_FLY: if (tick) begin
          nx = m_left ? m_x - STEP : m_x + STEP;
          if (nx < 0 || nx > XMAX) begin
            m_x = (nx < 0) ? 0 : XMAX;
            m_left = !m_left;
          end else m_x = nx;
          ny = m_up ? m_y - STEP : m_y + STEP;
          if (m_flights % 32 == 31) m_up = lf[0];
          if (ny < 0) begin m_y = 0; m_up = 0; end
          else if (ny > YMAX) begin m_y = YMAX; m_up = 1; end
          else m_y = ny;
          m_flights++;
          if (m_flights == FLY_TICKS) m_ph = P_ESC;
        end
        P_ESC: if (tick) begin
          if (m_y <= STEP) begin m_y = 0; m_vis = 0; m_esc = 1; m_ph = P_DONE; end
          else m_y = m_y - STEP;
        end
        P_HIT: if (tick) begin
          m_hold++;
          if (m_hold == HIT_HOLD) m_ph = P_FALL;
        end
        P_FALL: if (tick) begin
          ny = m_y + FALL_STEP;
          if (ny >= YMAX) begin m_y = YMAX; m_vis = 0; m_fall = 0; m_ph = P_DONE; end
          else m_y = ny;
        end
        P_DONE: if (tick) m_ph = hs ? P_SPAWN : P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic compare_all();
    chk("mdl_x", int'(duck_xpos), m_x);
    chk("mdl_y", int'(duck_ypos), m_y);
    chk("mdl_vis", int'(duck_visible), int'(m_vis));
    chk("mdl_left", int'(duck_facing_left), int'(m_left));
    chk("mdl_fall", int'(duck_falling), int'(m_fall));
    chk("mdl_esc", int'(duck_escaped), int'(m_esc));
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input bit ge, input bit hs, input bit kill);
    game_enable = ge; hunt_start = hs; duck_killed = kill;
    @(posedge clk);
    model_step(ge, hs, kill);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    game_enable = 1'b0; hunt_start = 1'b0; duck_killed = 1'b0;
    #1;
    chk("rst_x", int'(duck_xpos), 0);
    chk("rst_y", int'(duck_ypos), YMAX);
    chk("rst_vis", int'(duck_visible), 0);
    chk("rst_left", int'(duck_facing_left), 0);
    chk("rst_fall", int'(duck_falling), 0);
    chk("rst_esc", int'(duck_escaped), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bit found, got, done;
    bit [15:0] p;
    int x0, m, steps, prev, expx, yb;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 536};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 1'b0, 536};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b0, 1'b0, 532};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b0, 1'b0, 528};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 528};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1, 1'b0, 528};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 528};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 528};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4, 1'b1, 1'b1, 1'b0, 534};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4, 1'b0, 1'b0, 1'b0, 536};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 1'b0, 536};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 536};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0, 1'b0, 536};

    @(negedge clk);
    do_reset();

    // Spawn, kill on a tick, hold, fall, done, ignored kills.
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cycle(tbl[i].ge, tbl[i].hs, tbl[i].kill);
      chk($sformatf("tbl%0d_vis", i), int'(duck_visible), int'(tbl[i].vis));
      chk($sformatf("tbl%0d_fall", i), int'(duck_falling), int'(tbl[i].fall));
      chk($sformatf("tbl%0d_esc", i), int'(duck_escaped), int'(tbl[i].esc));
      chk($sformatf("tbl%0d_y", i), int'(duck_ypos), tbl[i].y);
    end

    // Right-edge bounce: wait for a spawn x of 934..958 (x%4==2) heading right.
    found = 0;
    p = '0;
    for (int i = 0; i < 8000 && !found; i++) begin
      p = lfsr_nx(m_lfsr);
      if (p[10] == 1'b0 && p[9:0] >= 10'd934 && p[9:0] <= 10'd958 && p[1:0] == 2'd2) found = 1;
      else cycle(1'b1, 1'b0, 1'b0);
    end
    chk("bounce_search", int'(found), 1);
    if (found) begin
      x0 = int'(p[9:0]);
      m = (958 - x0) / 4;
      cycle(1'b1, 1'b1, 1'b0);
      cycle(1'b1, 1'b1, 1'b0);
      chk("spawn_x", int'(duck_xpos), x0);
      chk("spawn_y", int'(duck_ypos), YMAX);
      chk("spawn_vis", int'(duck_visible), 1);
      chk("spawn_left", int'(duck_facing_left), 0);
      steps = 0;
      for (int c = 0; c < 64 && steps < m + 2; c++) begin
        prev = int'(duck_xpos);
        cycle(1'b1, 1'b1, 1'b0);
        if (int'(duck_xpos) != prev) begin
          steps++;
          if (steps <= m) expx = x0 + 4 * steps;
          else if (steps == m + 1) expx = 960;
          else expx = 956;
          chk($sformatf("bounce_x%0d", steps), int'(duck_xpos), expx);
          if (steps == m + 1) chk("bounce_left", int'(duck_facing_left), 1);
        end
      end
      chk("bounce_steps", steps, m + 2);
    end

    // Escape off the top, then respawn one tick later.
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (duck_escaped) got = 1;
    end
    chk("esc_seen", int'(got), 1);
    if (got) begin
      chk("esc_y", int'(duck_ypos), 0);
      chk("esc_vis", int'(duck_visible), 0);
      cycle(1'b1, 1'b1, 1'b0);
      chk("esc_width", int'(duck_escaped), 0);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b1, 1'b0);
      chk("respawn_wait_vis", int'(duck_visible), 0);
      cycle(1'b1, 1'b1, 1'b0);
      chk("respawn_vis", int'(duck_visible), 1);
      chk("respawn_y", int'(duck_ypos), YMAX);
    end

    // Kill on the very tick that would complete the escape.
    done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (m_ph == P_ESC && m_y <= STEP && m_div == MOVE_DIV - 1) begin
        yb = m_y;
        cycle(1'b1, 1'b1, 1'b1);
        chk("kbe_esc", int'(duck_escaped), 0);
        chk("kbe_fall", int'(duck_falling), 1);
        chk("kbe_vis", int'(duck_visible), 1);
        chk("kbe_y", int'(duck_ypos), yb);
        done = 1;
      end else cycle(1'b1, 1'b1, 1'b0);
    end
    chk("kbe_reached", int'(done), 1);

    // Disable while falling; prescaler must restart from zero on re-enable.
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (m_ph == P_FALL) done = 1;
      else cycle(1'b1, 1'b1, 1'b0);
    end
    chk("fall_reached", int'(done), 1);
    yb = m_y;
    cycle(1'b0, 1'b1, 1'b0);
    chk("dis_vis", int'(duck_visible), 0);
    chk("dis_fall", int'(duck_falling), 0);
    chk("dis_y", int'(duck_ypos), yb);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 1'b1);
    chk("dis_kill_vis", int'(duck_visible), 0);
    chk("dis_kill_fall", int'(duck_falling), 0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("reen_spawn_vis", int'(duck_visible), 0);
    cycle(1'b1, 1'b1, 1'b0);
    chk("reen_fly_vis", int'(duck_visible), 1);
    chk("reen_fly_y", int'(duck_ypos), YMAX);
    cycle(1'b1, 1'b1, 1'b0);
    chk("reen_pre_tick_y", int'(duck_ypos), YMAX);
    cycle(1'b1, 1'b1, 1'b0);
    chk("reen_tick_y", int'(duck_ypos), YMAX - STEP);

    // Asynchronous reset in the middle of a flight.
    chk("midfly_state", int'(m_ph == P_FLY), 1);
    do_reset();

    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 999) == 0) do_reset();
      else cycle($urandom_range(0, 99) < 97, $urandom_range(0, 99) < 90,
                 $urandom_range(0, 99) < 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
